ide_dma_engine: RTL

Multiword-DMA data mover between the IDE bus and a ping-pong word buffer. It is the successor to the PIO-only data path, and is parametrised in bank depth and transfer-length width. It drives dmarq and the data bus, qualifies strobes with dmack_, and tracks bank ownership with the AVR. It sits beside the taskfile logic: the AVR programs direction and length, then hands banks back and forth until done.

---
 rtl/ide_dma_pkg.sv | 18 +
 rtl/ide_strobe_detect.sv | 31 +++
 rtl/ide_dma_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ide_dma_pkg.sv
// Shared types and constants for the IDE multiword-DMA engine.
package ide_dma_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    REQ      = 2'd2
  } dma_state_e;

  localparam logic DIR_DEV2HOST = 1'b0;
  localparam logic DIR_HOST2DEV = 1'b1;

  // A bank is usable when it holds data to send (dev->host) or has room (host->dev).
  function automatic logic bank_usable(input logic dir, input logic full);
    return (dir == DIR_HOST2DEV) ? ~full : full;
  endfunction

endpackage

// File: rtl/ide_strobe_detect.sv
// Turns the synchronised dior_/diow_ strobes into a one-cycle event pulse,
// taken on the rising (trailing) edge of the strobe while dmack_ is low.
module ide_strobe_detect (
  input  logic clk,
  input  logic reset_,
  input  logic dir,
  input  logic dmack_in,
  input  logic dior_in,
  input  logic diow_in,
  output logic strobe_evt
);

  logic r_dior_q;
  logic r_diow_q;
  logic w_rise;

  // Strobes idle high, so the history resets high to avoid a false edge.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_dior_q <= 1'b1;
      r_diow_q <= 1'b1;
    end else begin
      r_dior_q <= dior_in;
      r_diow_q <= diow_in;
    end
  end

  assign w_rise     = dir ? (diow_in & ~r_diow_q) : (dior_in & ~r_dior_q);
  assign strobe_evt = w_rise & ~dmack_in;

endmodule

// File: rtl/ide_dma_engine.sv
// Multiword-DMA mover between the IDE bus and a two-bank ping-pong word
// buffer; bank ownership is passed back and forth with the AVR via bank_full.
module ide_dma_engine
  import ide_dma_pkg::*;
#(
  parameter int BANK_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               start,
  input  logic               dir,
  input  logic [CNT_W-1:0]   xfer_len,
  input  logic               abort,
  input  logic [1:0]         bank_ack,
  output logic [1:0]         bank_full,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   words_done,
  input  logic               dmack_in,
  input  logic               dior_in,
  input  logic               diow_in,
  input  logic [15:0]        dd_in,
  output logic [15:0]        dd_out,
  output logic               dd_oe,
  output logic               dmarq,
  output logic [BANK_AW:0]   buf_addr,
  input  logic [15:0]        buf_rdata,
  output logic [15:0]        buf_wdata,
  output logic               buf_we,
  output logic [1:0]         dbg_state
);

  dma_state_e       r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_words;
  logic [BANK_AW:0] r_ptr;
  logic [BANK_AW:0] r_waddr;
  logic [1:0]       r_full;
  logic             r_done;
  logic             r_err;
  logic             r_dmarq;
  logic             r_we;
  logic [15:0]      r_dd_out;
  logic [15:0]      r_wdata;

  logic             w_dir_eff;
  logic             w_evt;
  logic             w_bank;
  logic             w_bank_end;
  logic             w_final;
  logic             w_hand_over;
  logic [CNT_W-1:0] w_words_nxt;
  logic [1:0]       w_full_nxt;

  // Before a transfer is running the live dir input decides ack meaning.
  assign w_dir_eff   = (r_state == IDLE) ? dir : r_dir;
  assign w_bank      = r_ptr[BANK_AW];
  assign w_bank_end  = &r_ptr[BANK_AW-1:0];
  assign w_words_nxt = r_words + CNT_W'(1);
  assign w_final     = (w_words_nxt == r_len);
  assign w_hand_over = (r_state == REQ) && w_evt && !abort && (w_bank_end || w_final);

  ide_strobe_detect u_strobe (
    .clk        (clk),
    .reset_     (reset_),
    .dir        (w_dir_eff),
    .dmack_in   (dmack_in),
    .dior_in    (dior_in),
    .diow_in    (diow_in),
    .strobe_evt (w_evt)
  );

  // AVR hand-offs first, then the engine's own hand-over overrides them.
  always_comb begin
    w_full_nxt = r_full;
    for (int b = 0; b < 2; b++) begin
      if (bank_ack[b]) w_full_nxt[b] = (w_dir_eff == DIR_DEV2HOST);
    end
    if (w_hand_over) w_full_nxt[w_bank] = r_dir;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state  <= IDLE;
      r_dir    <= DIR_DEV2HOST;
      r_len    <= '0;
      r_words  <= '0;
      r_ptr    <= '0;
      r_waddr  <= '0;
      r_full   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_dmarq  <= 1'b0;
      r_we     <= 1'b0;
      r_dd_out <= '0;
      r_wdata  <= '0;
    end else begin
      r_we   <= 1'b0;
      r_full <= w_full_nxt;
      if (r_state != IDLE && r_dir == DIR_DEV2HOST) r_dd_out <= buf_rdata;
      if (w_evt && r_state != REQ) r_err <= 1'b1;
      if (abort) begin
        r_state <= IDLE;
        r_dmarq <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (xfer_len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= PREFETCH;
                r_dir   <= dir;
                r_len   <= xfer_len;
                r_ptr   <= '0;
                r_words <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
              end
            end
          end
          PREFETCH: begin
            if (bank_usable(r_dir, r_full[w_bank])) begin
              r_state <= REQ;
              r_dmarq <= 1'b1;
            end
          end
          REQ: begin
            if (w_evt) begin
              r_ptr   <= r_ptr + (BANK_AW+1)'(1);
              r_words <= w_words_nxt;
              if (r_dir == DIR_HOST2DEV) begin
                r_we    <= 1'b1;
                r_wdata <= dd_in;
                r_waddr <= r_ptr;
              end
              if (w_final) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
                r_dmarq <= 1'b0;
              end else if (w_bank_end && !bank_usable(r_dir, r_full[~w_bank])) begin
                r_state <= PREFETCH;
                r_dmarq <= 1'b0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bank_full  = r_full;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign words_done = r_words;
  assign dd_out     = r_dd_out;
  assign dd_oe      = busy & ~r_dir & ~dmack_in & ~dior_in;
  assign dmarq      = r_dmarq;
  assign buf_addr   = r_we ? r_waddr : r_ptr;
  assign buf_wdata  = r_wdata;
  assign buf_we     = r_we;
  assign dbg_state  = r_state;

endmodule
